sram_wb_ctrl: RTL
=================

Name: sram_wb_ctrl

Overview:
- Wishbone classic slave that owns one 1W/1R 32-bit SRAM macro. Port 0 is write-only and port 1 is read-only.
- Decodes a fixed address window and converts Wishbone reads and writes into SRAM chip-select, mask, address and data signals.
- Handles the macro's timing: inputs are registered on posedge, and write/read happen on the following negedge.
- Sits between the Caravel Wishbone bus and the SRAM; both SRAM clocks are tied to wb_clk_i at top level.

Parameters:
- DATA_WIDTH, 32, data bus width (fixed 32; NUM_WMASKS = DATA_WIDTH/8)
- NUM_WMASKS, 4, byte-lane mask width
- ADDR_WIDTH, 11, SRAM word-address width (2048 words)
- BASE_ADDR, 32'h3000_0000, byte base of the window; bits [ADDR_WIDTH+1:0] must be zero

Ports:
- wb_clk_i  in  1  clock; also drives SRAM clk0/clk1
- wb_rst_i  in  1  synchronous active-high reset
- wbs_cyc_i  in  1  bus cycle valid
- wbs_stb_i  in  1  strobe
- wbs_we_i  in  1  1 = write
- wbs_sel_i  in  4  byte lane select
- wbs_adr_i  in  32  byte address
- wbs_dat_i  in  32  write data
- wbs_ack_o  out  1  one-cycle acknowledge
- wbs_dat_o  out  32  read data
- sram_csb0  out  1  port-0 chip select, active low
- sram_wmask0  out  4  port-0 byte mask
- sram_addr0  out  ADDR_WIDTH  port-0 word address
- sram_din0  out  32  port-0 write data
- sram_csb1  out  1  port-1 chip select, active low
- sram_addr1  out  ADDR_WIDTH  port-1 word address
- sram_dout1  in  32  port-1 read data (valid after the negedge following capture)
- busy_o  out  1  high whenever state != IDLE

Behaviour:
- All outputs are registered.
- Reset values: csb0 = csb1 = 1; wmask0 = 0; addr0, addr1, din0 = 0; wbs_ack_o = 0; wbs_dat_o = 0; busy_o = 0; state = IDLE.
- hit = cyc & stb & (adr[31:ADDR_WIDTH+2] == BASE_ADDR[31:ADDR_WIDTH+2]).
- Word address = adr[ADDR_WIDTH+1:2]; adr[1:0] is ignored, and byte lanes come only from sel.
- Non-hit requests are ignored: no ack, state stays IDLE.
- IDLE, hit & we at edge E0:
  - Register csb0 = 0, wmask0 = sel, addr0, din0 = dat_i; go to WR.
- WR at E1:
  - SRAM captures the port-0 signals; its negedge writes the selected bytes.
  - Register csb0 = 1, wmask0 = 0, and ack = cyc_i; go to ACK.
  - Write ack is high for the cycle E1–E2.
- IDLE, hit & !we at E0:
  - Register csb1 = 0 and addr1; go to RD_ISSUE.
- RD_ISSUE at E1:
  - SRAM captures; register csb1 = 1; go to RD_DATA.
  - dout1 becomes valid at the negedge after E1.
- RD_DATA at E2:
  - wbs_dat_o <= sram_dout1; ack = cyc_i; go to ACK.
  - Read ack is high for the cycle E2–E3, with data stable in that cycle.
- ACK at next edge:
  - ack <= 0; go to IDLE.
  - A new request is never accepted in the ack cycle, so the minimum gap is one idle cycle between transactions.
- wbs_dat_o holds its last read value until the next read completes; it is not cleared after ack.
- sel = 0 write: csb0 still pulses and ack is still returned; memory is unchanged.
- Abort (cyc_i low at the ack-registering edge): ack is suppressed and state goes to ACK then IDLE as normal. A write already captured by the SRAM still lands.
- Reset mid-transaction: all registers return to reset values at the reset edge and no ack is issued.
  - The SRAM samples the pre-reset port values at that same edge. A write in WR state at reset therefore still commits; a read is discarded.
- Port 0 and port 1 are never active in the same cycle. One transaction is in flight at a time.

Decomposition:
- Package sram_wb_pkg holds:
  - state enum {IDLE, WR, RD_ISSUE, RD_DATA, ACK}, 3 bits;
  - default BASE_ADDR, DATA_WIDTH, ADDR_WIDTH, NUM_WMASKS constants;
  - a window-match function.
- No sub-module; single FSM plus output registers.
- The bench instantiates the existing FPGA SRAM model with both clocks on wb_clk_i.

Test Plan:
- Write then read: write 0xDEADBEEF to 0x3000_0010 with sel = 0xF, then read it back. The write ack arrives 1 cycle after strobe sampling; the read ack arrives 2 cycles after, with wbs_dat_o = 0xDEADBEEF. csb0 and csb1 each pulse low for exactly one cycle.
- Byte lanes: preload 0x11223344 at word 5, write 0xAABBCCDD with sel = 0b0101, then read. Readback = 0x11BB33DD.
- Window miss: access 0x3000_2000 (just above 2 KW) and 0x2000_0000. No ack within 10 cycles, csb0 = csb1 = 1, busy_o = 0.
- Back-to-back: 8 writes to words 0–7 with data = index·0x01010101, strobe held continuously, then 8 reads. Each ack is followed by one IDLE cycle, and all reads match.
- Abort and reset: drop cyc in RD_DATA, and confirm no ack and a return to IDLE in 2 cycles. Assert wb_rst_i during WR of 0xCAFEF00D to word 9, and confirm all outputs return to reset values the next cycle and a later read of word 9 returns 0xCAFEF00D. Assert reset in RD_ISSUE, and confirm no ack and wbs_dat_o = 0.
- Zero mask: write with sel = 0 to word 3 holding 0x12345678. Ack is returned and a readback is 0x12345678.

Source files
------------

// File: rtl/sram_wb_pkg.sv
// rtl/sram_wb_pkg.sv - shared constants, FSM state type and window decode for the SRAM Wishbone slave
package sram_wb_pkg;

  localparam int DEF_DATA_WIDTH = 32;
  localparam int DEF_NUM_WMASKS = DEF_DATA_WIDTH / 8;
  localparam int DEF_ADDR_WIDTH = 11;
  localparam logic [31:0] DEF_BASE_ADDR = 32'h3000_0000;

  typedef enum logic [2:0] {
    IDLE     = 3'd0,
    WR       = 3'd1,
    RD_ISSUE = 3'd2,
    RD_DATA  = 3'd3,
    ACK      = 3'd4
  } state_t;

  // True when every address bit above the SRAM word/byte offset matches the base.
  function automatic logic window_hit(logic [31:0] adr, logic [31:0] base, int unsigned addr_width);
    logic [31:0] diff;
    diff = (adr ^ base) >> (addr_width + 2);
    return diff == 32'd0;
  endfunction

endpackage

// File: rtl/sram_wb_ctrl.sv
// rtl/sram_wb_ctrl.sv - Wishbone classic slave driving a 1W/1R SRAM macro (posedge capture, negedge access)
module sram_wb_ctrl #(
  parameter int DATA_WIDTH = sram_wb_pkg::DEF_DATA_WIDTH,
  parameter int NUM_WMASKS = sram_wb_pkg::DEF_NUM_WMASKS,
  parameter int ADDR_WIDTH = sram_wb_pkg::DEF_ADDR_WIDTH,
  parameter logic [31:0] BASE_ADDR = sram_wb_pkg::DEF_BASE_ADDR
) (
  input  logic                  wb_clk_i,
  input  logic                  wb_rst_i,
  input  logic                  wbs_cyc_i,
  input  logic                  wbs_stb_i,
  input  logic                  wbs_we_i,
  input  logic [NUM_WMASKS-1:0] wbs_sel_i,
  input  logic [31:0]           wbs_adr_i,
  input  logic [DATA_WIDTH-1:0] wbs_dat_i,
  output logic                  wbs_ack_o,
  output logic [DATA_WIDTH-1:0] wbs_dat_o,
  output logic                  sram_csb0,
  output logic [NUM_WMASKS-1:0] sram_wmask0,
  output logic [ADDR_WIDTH-1:0] sram_addr0,
  output logic [DATA_WIDTH-1:0] sram_din0,
  output logic                  sram_csb1,
  output logic [ADDR_WIDTH-1:0] sram_addr1,
  input  logic [DATA_WIDTH-1:0] sram_dout1,
  output logic                  busy_o
);
  import sram_wb_pkg::*;

  state_t                state;
  logic                  hit;
  logic [ADDR_WIDTH-1:0] word_addr;

  assign hit       = wbs_cyc_i & wbs_stb_i & window_hit(wbs_adr_i, BASE_ADDR, ADDR_WIDTH);
  assign word_addr = wbs_adr_i[ADDR_WIDTH+1:2];

  always_ff @(posedge wb_clk_i) begin
    if (wb_rst_i) begin
      state       <= IDLE;
      sram_csb0   <= 1'b1;
      sram_wmask0 <= '0;
      sram_addr0  <= '0;
      sram_din0   <= '0;
      sram_csb1   <= 1'b1;
      sram_addr1  <= '0;
      wbs_ack_o   <= 1'b0;
      wbs_dat_o   <= '0;
      busy_o      <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (hit) begin
            busy_o <= 1'b1;
            if (wbs_we_i) begin
              sram_csb0   <= 1'b0;
              sram_wmask0 <= wbs_sel_i;
              sram_addr0  <= word_addr;
              sram_din0   <= wbs_dat_i;
              state       <= WR;
            end else begin
              sram_csb1  <= 1'b0;
              sram_addr1 <= word_addr;
              state      <= RD_ISSUE;
            end
          end
        end
        // The macro samples port 0 on this edge, so the write commits even if the master has gone.
        WR: begin
          sram_csb0   <= 1'b1;
          sram_wmask0 <= '0;
          wbs_ack_o   <= wbs_cyc_i;
          state       <= ACK;
        end
        RD_ISSUE: begin
          sram_csb1 <= 1'b1;
          state     <= RD_DATA;
        end
        // dout1 settled on the negedge after capture; it is held in wbs_dat_o until the next read.
        RD_DATA: begin
          wbs_dat_o <= sram_dout1;
          wbs_ack_o <= wbs_cyc_i;
          state     <= ACK;
        end
        ACK: begin
          wbs_ack_o <= 1'b0;
          busy_o    <= 1'b0;
          state     <= IDLE;
        end
        default: begin
          sram_csb0   <= 1'b1;
          sram_wmask0 <= '0;
          sram_csb1   <= 1'b1;
          wbs_ack_o   <= 1'b0;
          busy_o      <= 1'b0;
          state       <= IDLE;
        end
      endcase
    end
  end

endmodule
